// File: rtl/rotor_seq.sv
// Rotate-command sequencer: turns one (data, dir, count) command into the rotor's load/step pin sequence.
// Define ROTOR_SEQ_MODCNT_EN to reduce the step count modulo WIDTH (full-circle steps dropped).
module rotor_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_cnt,
    output logic             load,
    output logic             sigright,
    output logic             sigleft,
    output logic [WIDTH-1:0] rot_in,
    output logic             busy,
    output logic             done,
    output logic [15:0]      op_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_ROT  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_cmd_ready;
    logic               r_load;
    logic               r_sigright;
    logic               r_sigleft;
    logic [WIDTH-1:0]   r_rot_in;
    logic               r_busy;
    logic               r_done;
    logic [15:0]        r_op_count;
    logic               r_dir;
    logic [CNT_W-1:0]   r_step;

    logic [CNT_W-1:0]   w_eff_cnt;
    logic [15:0]        w_op_next;

`ifdef ROTOR_SEQ_MODCNT_EN
    // WIDTH is a power of two, so masking keeps cmd_cnt mod WIDTH.
    assign w_eff_cnt = cmd_cnt & CNT_W'(WIDTH - 1);
`else
    assign w_eff_cnt = cmd_cnt;
`endif

    assign w_op_next = (r_op_count == 16'hFFFF) ? r_op_count : r_op_count + 16'd1;

    // NOTE: every output is a flop written with <= in one clocked block, so the
    // pins never see cmd_* combinationally and the state/output pair cannot race.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b1;
            r_load      <= 1'b0;
            r_sigright  <= 1'b0;
            r_sigleft   <= 1'b0;
            r_rot_in    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_op_count  <= 16'd0;
            r_dir       <= 1'b0;
            r_step      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid && r_cmd_ready) begin
                        r_state     <= S_LOAD;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_load      <= 1'b1;
                        r_rot_in    <= cmd_data;
                        r_dir       <= cmd_dir;
                        r_step      <= w_eff_cnt;
                    end
                end
                S_LOAD: begin
                    r_load <= 1'b0;
                    if (r_step != '0) begin
                        r_state    <= S_ROT;
                        r_sigright <= ~r_dir;
                        r_sigleft  <= r_dir;
                    end else begin
                        r_state    <= S_DONE;
                        r_done     <= 1'b1;
                        r_op_count <= w_op_next;
                    end
                end
                S_ROT: begin
                    // r_step counts the steps still to issue including this one,
                    // so it never drops below 1 here and cannot underflow.
                    r_step <= r_step - CNT_W'(1);
                    if (r_step == CNT_W'(1)) begin
                        r_state    <= S_DONE;
                        r_sigright <= 1'b0;
                        r_sigleft  <= 1'b0;
                        r_done     <= 1'b1;
                        r_op_count <= w_op_next;
                    end
                end
                S_DONE: begin
                    r_state     <= S_IDLE;
                    r_done      <= 1'b0;
                    r_busy      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_cmd_ready <= 1'b1;
                    r_load      <= 1'b0;
                    r_sigright  <= 1'b0;
                    r_sigleft   <= 1'b0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign load      = r_load;
    assign sigright  = r_sigright;
    assign sigleft   = r_sigleft;
    assign rot_in    = r_rot_in;
    assign busy      = r_busy;
    assign done      = r_done;
    assign op_count  = r_op_count;

endmodule

// File: tb/tb_rotor_seq.sv
// Self-checking bench for rotor_seq: vector table of rotate commands plus reset and back-to-back sequences.
// Honours ROTOR_SEQ_MODCNT_EN the same way the design does.
module tb_rotor_seq;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_data;
    logic       cmd_dir;
    logic [3:0] cmd_cnt;
    logic       load;
    logic       sigright;
    logic       sigleft;
    logic [7:0] rot_in;
    logic       busy;
    logic       done;
    logic [15:0] op_count;

    int n_checks = 0;
    int n_errors = 0;

    rotor_seq #(.WIDTH(8), .CNT_W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_data (cmd_data),
        .cmd_dir  (cmd_dir),
        .cmd_cnt  (cmd_cnt),
        .load     (load),
        .sigright (sigright),
        .sigleft  (sigleft),
        .rot_in   (rot_in),
        .busy     (busy),
        .done     (done),
        .op_count (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference rotor stage driven by the sequencer pins.
    logic [7:0] r_model;
    always @(posedge clk) begin
        if (load)          r_model <= rot_in;
        else if (sigright) r_model <= {r_model[0], r_model[7:1]};
        else if (sigleft)  r_model <= {r_model[6:0], r_model[7]};
    end

    typedef struct {
        logic [7:0] data;
        logic       dir;
        logic [3:0] cnt;
        logic [7:0] exp_out;
        int         exp_steps;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int hot_count();
        return int'(load) + int'(sigright) + int'(sigleft);
    endfunction

    task automatic run_cmd(input logic [7:0] d, input logic dr, input logic [3:0] c,
                           input logic [7:0] exp_out, input int exp_steps,
                           input int exp_ops, input string tag);
        int  lat;
        int  right_n;
        int  left_n;
        int  bad_n;
        bit  seen;
        @(negedge clk);
        check({tag, " ready_idle"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_data  = d;
        cmd_dir   = dr;
        cmd_cnt   = c;
        @(negedge clk);
        cmd_valid = 1'b0;
        check({tag, " load_phase"}, {load, sigright, sigleft, busy, cmd_ready, done}, 6'b100100);
        check({tag, " rot_in"}, 32'(rot_in), 32'(d));
        lat = 1; seen = 1'b0; right_n = 0; left_n = 0; bad_n = 0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (hot_count() > 1 || load) bad_n++;
            if (busy !== 1'b1 || cmd_ready !== 1'b0 || rot_in !== d) bad_n++;
            if (sigright) right_n++;
            if (sigleft)  left_n++;
            if (done) seen = 1'b1;
        end
        check({tag, " done_seen"}, 32'(seen), 32'd1);
        check({tag, " done_latency"}, 32'(lat), 32'(exp_steps + 2));
        check({tag, " right_steps"}, 32'(right_n), dr ? 32'd0 : 32'(exp_steps));
        check({tag, " left_steps"}, 32'(left_n), dr ? 32'(exp_steps) : 32'd0);
        check({tag, " invariants"}, 32'(bad_n), 32'd0);
        check({tag, " rotor_out"}, 32'(r_model), 32'(exp_out));
        check({tag, " op_count"}, 32'(op_count), 32'(exp_ops));
        @(negedge clk);
        check({tag, " back_idle"}, {cmd_ready, busy, done, load, sigright, sigleft}, 6'b100000);
    endtask

    initial begin
        int  pulses;
        int  ready_n;
        int  done_n;
        int  bad_n;
        int  gap_bad;
        int  last_ready;
        bit  drop_next;
        logic [7:0] saved;

        // data, dir, cnt, expected rotor out, expected step cycles
        vecs[0] = '{8'b10110011, 1'b0, 4'd3,  8'b01110110, 3};
        vecs[1] = '{8'b01110110, 1'b1, 4'd3,  8'b10110011, 3};
        vecs[2] = '{8'hA5,       1'b0, 4'd0,  8'hA5,       0};
`ifdef ROTOR_SEQ_MODCNT_EN
        vecs[3] = '{8'h01,       1'b0, 4'd11, 8'h20,       3};
        vecs[4] = '{8'h81,       1'b1, 4'd15, 8'hC0,       7};
        vecs[5] = '{8'h3C,       1'b1, 4'd8,  8'h3C,       0};
`else
        vecs[3] = '{8'h01,       1'b0, 4'd11, 8'h20,       11};
        vecs[4] = '{8'h81,       1'b1, 4'd15, 8'hC0,       15};
        vecs[5] = '{8'h3C,       1'b1, 4'd8,  8'h3C,       8};
`endif
        vecs[6] = '{8'h12,       1'b1, 4'd1,  8'h24,       1};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_data = '0; cmd_dir = 1'b0; cmd_cnt = '0;
        repeat (3) @(negedge clk);
        check("reset outputs", {load, sigright, sigleft, busy, done}, 5'b0);
        check("reset rot_in", 32'(rot_in), 32'd0);
        check("reset op_count", 32'(op_count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready after release", {cmd_ready, busy}, 2'b10);

        for (int i = 0; i < 7; i++)
            run_cmd(vecs[i].data, vecs[i].dir, vecs[i].cnt, vecs[i].exp_out,
                    vecs[i].exp_steps, i + 1, $sformatf("vec%0d", i));

        // Reset in the middle of a rotate sequence.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_data = 8'hF0; cmd_dir = 1'b0; cmd_cnt = 4'd6;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("midrot stepping", 32'(sigright), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrot reset outputs", {load, sigright, sigleft, busy, done}, 5'b0);
        check("midrot reset op_count", 32'(op_count), 32'd0);
        saved = r_model;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrot ready after release", {cmd_ready, busy}, 2'b10);
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (hot_count() != 0 || done) pulses++;
        end
        check("midrot no further activity", 32'(pulses), 32'd0);
        check("midrot rotor frozen", 32'(r_model), 32'(saved));

        // cmd_valid held high across four commands of count 2 (period 5).
        ready_n = 0; done_n = 0; bad_n = 0; gap_bad = 0; last_ready = 0; drop_next = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_data = 8'h5A; cmd_dir = 1'b1; cmd_cnt = 4'd2;
        for (int cyc = 0; cyc < 100 && done_n < 4; cyc++) begin
            if (cyc != 0) @(negedge clk);
            if (drop_next) cmd_valid = 1'b0;
            if (hot_count() > 1) bad_n++;
            if (busy === cmd_ready) bad_n++;
            if (done) done_n++;
            if (cmd_ready && cmd_valid) begin
                if (ready_n > 0 && cyc - last_ready != 5) gap_bad++;
                last_ready = cyc;
                ready_n++;
                if (ready_n == 4) drop_next = 1'b1;
            end
        end
        cmd_valid = 1'b0;
        check("b2b accepts", 32'(ready_n), 32'd4);
        check("b2b dones", 32'(done_n), 32'd4);
        check("b2b accept spacing", 32'(gap_bad), 32'd0);
        check("b2b invariants", 32'(bad_n), 32'd0);
        check("b2b op_count", 32'(op_count), 32'd4);
        check("b2b rotor_out", 32'(r_model), 32'h69);
        @(negedge clk);
        check("b2b back_idle", {cmd_ready, busy, done}, 3'b100);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
